// File: rtl/backlight_fader.sv
// rtl/backlight_fader.sv - ramps the backlight duty code toward a written target at a programmable rate
module backlight_fader #(
    parameter int STEP_DIV = 156250,
    parameter int DIV_W    = 18
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_target,
    input  logic       i_target_we,
    input  logic [3:0] i_step,
    input  logic       i_blank,
    output logic [7:0] o_duty,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RAMP = 1'b1
    } state_t;

    localparam logic [DIV_W-1:0] LP_LAST = DIV_W'(STEP_DIV - 1);

    state_t           r_state;
    logic [DIV_W-1:0] r_presc;
    logic [7:0]       r_target;
    logic [7:0]       r_duty;
    logic             r_done;
    logic             r_blanked;

    logic             w_up;
    logic [8:0]       w_diff;
    logic             w_step_edge;
    logic             w_close;
    logic [7:0]       w_next_duty;

    // Distance to target in 9 bits so the comparison with the step size cannot wrap.
    assign w_up        = (r_target > r_duty);
    assign w_diff      = w_up ? ({1'b0, r_target} - {1'b0, r_duty})
                              : ({1'b0, r_duty} - {1'b0, r_target});
    assign w_step_edge = (r_state == S_RAMP) && (r_presc == LP_LAST);
    // A step size of zero seen at a step edge finishes the ramp rather than stalling it.
    assign w_close     = (i_step == 4'd0) || (w_diff <= {5'd0, i_step});
    // Moving by i_step is only taken when the distance exceeds it, so no overshoot or wrap.
    assign w_next_duty = w_close ? r_target
                       : (w_up ? (r_duty + {4'd0, i_step}) : (r_duty - {4'd0, i_step}));

    // Ramp state machine: blanking first, then writes, then blank release, then stepping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_target  <= 8'd0;
            r_duty    <= 8'd0;
            r_done    <= 1'b0;
            r_blanked <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_blanked <= i_blank;
            if (i_target_we) begin
                r_target <= i_target;
            end
            if (i_blank) begin
                r_duty  <= 8'd0;
                r_state <= S_IDLE;
                r_presc <= '0;
            end else if (i_target_we) begin
                r_presc <= '0;
                if (i_step == 4'd0) begin
                    r_duty  <= i_target;
                    r_state <= S_IDLE;
                    r_done  <= (r_state == S_RAMP);
                end else if (i_target != r_duty) begin
                    r_state <= S_RAMP;
                end else begin
                    r_state <= S_IDLE;
                end
            end else if (r_blanked) begin
                // Soft restart from zero after blanking if there is somewhere to go.
                r_presc <= '0;
                r_state <= (r_target != 8'd0) ? S_RAMP : S_IDLE;
            end else if (r_state == S_RAMP) begin
                if (w_step_edge) begin
                    r_presc <= '0;
                    r_duty  <= w_next_duty;
                    if (w_close) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end else begin
                r_presc <= '0;
            end
        end
    end

    assign o_duty = r_duty;
    assign o_busy = (r_state == S_RAMP);
    assign o_done = r_done;

endmodule

// File: tb/tb_backlight_fader.sv
// tb/tb_backlight_fader.sv - self-checking bench for backlight_fader against a behavioural model
module tb_backlight_fader;

    localparam int STEP_DIV = 4;
    localparam int DIV_W    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] target = 8'd0;
    logic       target_we = 1'b0;
    logic [3:0] step = 4'd0;
    logic       blank = 1'b0;
    logic [7:0] duty;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_pass  = 0;

    // behavioural model state
    int m_target, m_duty, m_wait;
    bit m_ramp, m_done, m_blanked;

    backlight_fader #(.STEP_DIV(STEP_DIV), .DIV_W(DIV_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_target(target), .i_target_we(target_we),
        .i_step(step), .i_blank(blank), .o_duty(duty), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_target = 0; m_duty = 0; m_wait = STEP_DIV;
        m_ramp = 0; m_done = 0; m_blanked = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs present before the edge.
    task automatic model_edge();
        int d;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_done = 0;
        if (target_we) m_target = target;
        if (blank) begin
            m_duty = 0; m_ramp = 0; m_wait = STEP_DIV;
        end else if (target_we) begin
            m_wait = STEP_DIV;
            if (step == 0) begin
                m_done = m_ramp; m_duty = m_target; m_ramp = 0;
            end else begin
                m_ramp = (m_target != m_duty);
            end
        end else if (m_blanked) begin
            m_wait = STEP_DIV;
            m_ramp = (m_target != 0);
        end else if (m_ramp) begin
            m_wait--;
            if (m_wait == 0) begin
                m_wait = STEP_DIV;
                d = (m_target > m_duty) ? m_target - m_duty : m_duty - m_target;
                if (step == 0 || d <= step) begin
                    m_duty = m_target; m_ramp = 0; m_done = 1;
                end else begin
                    m_duty = (m_target > m_duty) ? m_duty + step : m_duty - step;
                end
            end
        end
        m_blanked = blank;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("duty", duty, m_duty);
        chk("busy", busy, int'(m_ramp));
        chk("done", done, int'(m_done));
    endtask

    task automatic wr(input int t, input int s);
        target = 8'(t); step = 4'(s); target_we = 1'b1;
        tick();
        target_we = 1'b0;
    endtask

    initial begin
        int dones;
        bit hit;
        model_reset();
        // reset state
        tick(); tick();
        chk("rst_duty", duty, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // ramp 0 -> 5, step 1
        wr(5, 1);
        chk("t1_busy0", busy, 1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k % 4 == 0) chk("t1_duty", duty, k / 4);
        end
        chk("t1_busy_end", busy, 0); chk("t1_done", done, 1);
        tick();
        chk("t1_done_once", done, 0);

        // saturating steps
        wr(250, 0);
        chk("sat_jump", duty, 250);
        wr(255, 15);
        for (int k = 0; k < STEP_DIV; k++) tick();
        chk("sat_up", duty, 255); chk("sat_up_done", done, 1);
        wr(10, 0);
        wr(0, 15);
        for (int k = 0; k < STEP_DIV; k++) tick();
        chk("sat_dn", duty, 0); chk("sat_dn_done", done, 1);

        // mid-ramp reversal
        dones = 0; hit = 0;
        wr(100, 10);
        for (int k = 0; k < 100 && !hit; k++) begin
            tick(); dones += int'(done);
            hit = (duty == 8'd40);
        end
        chk("rev_reach40", int'(hit), 1);
        wr(20, 10);
        for (int k = 1; k <= 12; k++) begin
            tick(); dones += int'(done);
            if (k == 4) chk("rev_30", duty, 30);
            if (k == 8) chk("rev_20", duty, 20);
        end
        chk("rev_dones", dones, 1);

        // immediate jump and no-op write
        wr(200, 0);
        chk("jump_duty", duty, 200); chk("jump_busy", busy, 0);
        wr(200, 5);
        chk("noop_busy", busy, 0);
        tick();
        chk("noop_done", done, 0);

        // blanking mid-ramp
        wr(0, 0);
        hit = 0;
        wr(128, 6);
        for (int k = 0; k < 100 && !hit; k++) begin
            tick(); hit = (duty == 8'd60);
        end
        chk("blk_reach60", int'(hit), 1);
        blank = 1'b1;
        tick();
        chk("blk_duty", duty, 0); chk("blk_busy", busy, 0);
        wr(90, 6);
        tick();
        chk("blk_wr_duty", duty, 0);
        blank = 1'b0;
        dones = 0; hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            tick(); dones += int'(done);
            hit = (done == 1'b1);
        end
        chk("blk_rel_done", dones, 1); chk("blk_rel_duty", duty, 90);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            target_we = ($urandom_range(0, 7) == 0);
            target    = 8'($urandom);
            step      = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 39) == 0) blank = ~blank;
            tick();
        end
        target_we = 1'b0; blank = 1'b0;
        tick(); tick();

        // asynchronous reset between edges during a ramp
        wr(0, 0);
        wr(200, 3);
        for (int k = 0; k < 6; k++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_duty", duty, 0); chk("arst_busy", busy, 0); chk("arst_done", done, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("arst_hold", duty, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
